// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Issue/response bundle between the pipeline (master) and the
//                iterative multiply/divide unit (slave).
//                  start_i  - request, accepted only when the unit is idle
//                  kill_i   - flush, aborts any in-flight operation
//                  funct3_i - RV M-extension funct3 selector
//                  rs1_i    - operand A (multiplicand / dividend)
//                  rs2_i    - operand B (multiplier / divisor)
//                  busy_o   - unit is not idle
//                  done_o   - one-cycle pulse, result_o valid
//                  result_o - result, held until the next accepted operation
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            kill_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, kill_i, funct3_i, rs1_i, rs2_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, kill_i, funct3_i, rs1_i, rs2_i,
        output busy_o, done_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M/RV64M multiply/divide unit. One radix-2
//                step per cycle: shift-add multiply into a 2*XLEN
//                accumulator, restoring shift-subtract divide. Operands are
//                converted to magnitudes on accept and the sign is restored
//                on the final step. Divide-by-zero and signed overflow
//                finish without iterating.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                bus       - muldiv_unit_if.slave (start/kill/funct3/rs1/rs2
//                            in, busy/done/result out)
//  Options     : MULDIV_FAST_MUL_EN - when defined, funct3 0-3 use a single
//                cycle combinational multiplier; divides stay iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    localparam logic [XLEN-1:0]  c_zero     = '0;
    localparam logic [XLEN-1:0]  c_ones     = '1;
    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    // Multiply: {partial high, multiplier shifting out}. Divide: {rem, quot}.
    logic [2*XLEN-1:0] r_acc, w_acc_nxt;
    logic [XLEN-1:0]   r_b, w_b_nxt;          // multiplicand or divisor magnitude
    logic [2:0]        r_op, w_op_nxt;
    logic              r_neg_q, w_neg_q_nxt;  // negate product / quotient
    logic              r_neg_r, w_neg_r_nxt;  // negate remainder (sign of A)
    logic [XLEN-1:0]   r_result, w_result_nxt;

    // ---------------- operand decode on accept ----------------
    logic [2:0]      w_f;
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;
    logic            w_div_zero, w_div_ovf;

    assign w_f        = bus.funct3_i;
    assign w_a_signed = (w_f == 3'd1) || (w_f == 3'd2) || (w_f == 3'd4) || (w_f == 3'd6);
    assign w_b_signed = (w_f == 3'd1) || (w_f == 3'd4) || (w_f == 3'd6);
    assign w_a_neg    = w_a_signed && bus.rs1_i[XLEN-1];
    assign w_b_neg    = w_b_signed && bus.rs2_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? (c_zero - bus.rs1_i) : bus.rs1_i;
    assign w_b_mag    = w_b_neg ? (c_zero - bus.rs2_i) : bus.rs2_i;
    assign w_div_zero = w_f[2] && (bus.rs2_i == c_zero);
    assign w_div_ovf  = w_f[2] && !w_f[0] && (bus.rs1_i == c_int_min) && (bus.rs2_i == c_ones);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    assign w_special_res = w_div_zero ? (w_f[1] ? bus.rs1_i : c_ones)
                                      : (w_f[1] ? c_zero    : bus.rs1_i);

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extend to 2*XLEN so the low 2*XLEN product bits are exact for
    // every signedness combination.
    logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fa       = {{XLEN{w_a_signed & bus.rs1_i[XLEN-1]}}, bus.rs1_i};
    assign w_fb       = {{XLEN{w_b_signed & bus.rs2_i[XLEN-1]}}, bus.rs2_i};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast_res = (w_f == 3'd0) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     w_mul_sum, w_div_trial, w_div_diff;
    logic [2*XLEN-1:0] w_mul_step, w_div_step, w_step, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_final;

    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {1'b0, c_zero});
    assign w_mul_step  = {w_mul_sum, r_acc[XLEN-1:1]};
    // Trial remainder needs one extra bit: 2*rem + 1 can exceed XLEN bits.
    assign w_div_trial = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_trial - {1'b0, r_b};
    assign w_div_step  = {w_div_diff[XLEN] ? w_div_trial[XLEN-1:0] : w_div_diff[XLEN-1:0],
                          r_acc[XLEN-2:0], ~w_div_diff[XLEN]};
    assign w_step      = r_op[2] ? w_div_step : w_mul_step;

    assign w_prod = r_neg_q ? ({2*XLEN{1'b0}} - w_step) : w_step;
    assign w_quot = r_neg_q ? (c_zero - w_step[XLEN-1:0]) : w_step[XLEN-1:0];
    assign w_rem  = r_neg_r ? (c_zero - w_step[2*XLEN-1:XLEN]) : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_prod[2*XLEN-1:XLEN];
        case (r_op)
            3'd0:       w_final = w_prod[XLEN-1:0];
            3'd4, 3'd5: w_final = w_quot;
            3'd6, 3'd7: w_final = w_rem;
            default:    w_final = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- FSM: next state and datapath ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.kill_i) begin
                    w_op_nxt    = w_f;
                    w_neg_q_nxt = w_a_neg ^ w_b_neg;
                    w_neg_r_nxt = w_a_neg;
                    w_cnt_nxt   = c_cnt_init;
                    if (w_f[2]) begin
                        w_acc_nxt = {c_zero, w_a_mag};
                        w_b_nxt   = w_b_mag;
                    end else begin
                        w_acc_nxt = {c_zero, w_b_mag};
                        w_b_nxt   = w_a_mag;
                    end
                    if (w_div_zero || w_div_ovf) begin
                        w_result_nxt = w_special_res;
                        w_state_nxt  = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!w_f[2]) begin
                        w_result_nxt = w_fast_res;
                        w_state_nxt  = S_DONE;
                    end
`endif
                    else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.kill_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt = w_step;
                    w_cnt_nxt = r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        w_result_nxt = w_final;
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign bus.busy_o   = (r_state != S_IDLE);
    assign bus.done_o   = (r_state == S_DONE);
    assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit (XLEN=32). Stimulus pushes
//                expected result and latency; a negedge monitor pops and
//                compares on every done_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit c_fast = 1'b1;
`else
    localparam bit c_fast = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        int          e0;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_result = '0;
    bit          chk_idle_next = 1'b0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic from the RV M-extension rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f)
            3'd0: begin p = ua * ub;            r = p[31:0];  end
            3'd1: begin p = sa * sb;            r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  r = p[63:32]; end
            3'd3: begin p = ua * ub;            r = p[63:32]; end
            3'd4: if (b == 0) r = '1;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                  else begin p = sa / sb; r = p[31:0]; end
            3'd5: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                  else begin p = sa % sb; r = p[31:0]; end
            default: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 0;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        if (!f[2] && c_fast) return 0;
        return XLEN;
    endfunction

    // Issue one op once the unit is idle; returns just after the accept edge.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit use_c, input logic [31:0] c);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy_o) chk("issue_wait_timeout", 32'd1, 32'd0);
        bus.funct3_i = f;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        e.res = use_c ? c : model(f, a, b);
        e.e0  = cyc;
        e.lat = latency(f, a, b);
        q.push_back(e);
        last_result = e.res;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.busy_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || bus.busy_o) chk("idle_wait_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: compare each done_o pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_idle_next) begin
                chk("busy_after_done", {31'b0, bus.busy_o}, 32'd0);
                chk_idle_next = 1'b0;
            end
            if (bus.done_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", bus.result_o, e.res);
                    chk("latency", 32'(cyc - e.e0), 32'(e.lat));
                    chk("busy_with_done", {31'b0, bus.busy_o}, 32'd1);
                    chk_idle_next = 1'b1;
                end
            end
        end
    end

    logic [2:0]  d_f [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a [11] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h64, 32'h64, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2,
                              32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_r [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'h64, 32'h8000_0000, 32'h0};

    initial begin
        logic [31:0] prev;
        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.funct3_i = '0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;

        // Reset state
        #12;
        chk("reset_busy",   {31'b0, bus.busy_o}, 32'd0);
        chk("reset_done",   {31'b0, bus.done_o}, 32'd0);
        chk("reset_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 11; i++) do_op(d_f[i], d_a[i], d_b[i], 1'b1, d_r[i]);
        wait_idle();

        // Kill at E0+10 together with a new start; the new start is dropped
        prev = last_result;
        @(negedge clk);
        bus.funct3_i = 3'd4;
        bus.rs1_i    = 32'd1000;
        bus.rs2_i    = 32'd7;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.kill_i   = 1'b1;
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'd5;
        bus.rs1_i    = 32'd55;
        bus.rs2_i    = 32'd5;
        @(posedge clk);
        #1;
        bus.kill_i  = 1'b0;
        bus.start_i = 1'b0;
        chk("kill_busy",   {31'b0, bus.busy_o}, 32'd0);
        chk("kill_result", bus.result_o, prev);
        @(negedge clk);
        chk("kill_start_dropped", {31'b0, bus.busy_o}, 32'd0);
        chk("kill_no_done",       {31'b0, bus.done_o}, 32'd0);
        @(posedge clk);
        do_op(3'd6, 32'hFFFF_FC18, 32'd7, 1'b0, 32'd0);
        wait_idle();

        // Start while busy is ignored
        do_op(3'd5, 32'd12345, 32'd10, 1'b0, 32'd0);
        repeat (5) @(negedge clk);
        bus.funct3_i = 3'd0;
        bus.rs1_i    = 32'hDEAD_BEEF;
        bus.rs2_i    = 32'd3;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_idle();

        // Asynchronous reset mid-CALC
        do_op(3'd3, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 32'd0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'b0, bus.busy_o}, 32'd0);
        chk("arst_done",   {31'b0, bus.done_o}, 32'd0);
        chk("arst_result", bus.result_o, 32'd0);
        q.delete();
        chk_idle_next = 1'b0;
        last_result   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_release_busy", {31'b0, bus.busy_o}, 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f, a, b, 1'b0, 32'd0);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
